vga_sync: RTL

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_sync.sv | 86 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and the coordinate type shared by the
// VGA sync generator and its per-axis counters.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOT = axis_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOT = axis_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with sync and active flags
// registered from the next-state count so they line up with the count itself.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VIS  = DEF_H_VIS,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n,
    output logic   active
);

    localparam int     TOT     = axis_total(VIS, FP, SYNC, BP);
    localparam coord_t LAST    = coord_t'(TOT - 1);
    localparam coord_t VIS_END = coord_t'(VIS);
    localparam coord_t SYNC_LO = coord_t'(VIS + FP);
    localparam coord_t SYNC_HI = coord_t'(VIS + FP + SYNC);

    coord_t cnt_nxt;

    assign wrap = en && (count == LAST);

    always_comb begin
        cnt_nxt = count;
        if (en)
            cnt_nxt = wrap ? '0 : count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            sync_n <= 1'b1;
            active <= 1'b1;
        end else begin
            count  <= cnt_nxt;
            sync_n <= !((cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI));
            active <= (cnt_nxt < VIS_END);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator in the clk domain; the pixel clock arrives as data and
// its rising edges become single-cycle advance ticks.
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dclk,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic [9:0]   px,
    output logic [9:0]   py,
    output logic         pix_tick,
    output logic         frame_start
);

    logic   dclk_q;
    logic   armed;
    logic   tick;
    logic   h_wrap, v_wrap;
    logic   h_active, v_active;
    coord_t hc, vc;

    // armed masks the first cycle after reset, so a dclk already high at
    // release is not mistaken for a rising edge.
    assign tick = dclk & ~dclk_q & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dclk_q      <= 1'b0;
            armed       <= 1'b0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            dclk_q      <= dclk;
            armed       <= 1'b1;
            pix_tick    <= tick;
            frame_start <= tick & h_wrap & v_wrap;
        end
    end

    vga_axis_counter #(
        .VIS (H_VIS),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP)
    ) u_h (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .count (hc),
        .wrap  (h_wrap),
        .sync_n(hsync),
        .active(h_active)
    );

    vga_axis_counter #(
        .VIS (V_VIS),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP)
    ) u_v (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (vc),
        .wrap  (v_wrap),
        .sync_n(vsync),
        .active(v_active)
    );

    assign video_on = h_active & v_active;
    assign px       = hc;
    assign py       = vc;

endmodule
